codificador_alertas: RTL and testbench

//  Producer side of the alert decoder's interface. Turns raw sensor samples
//  (temperature, heart rate, smoke, position switch, arm button) into the six

---
 rtl/codificador_alertas_pkg.sv | 30 +++
 rtl/codificador_alertas_if.sv | 25 ++
 rtl/codificador_alertas_antirrebote.sv | 41 ++++
 rtl/codificador_alertas.sv | 195 +++++++++++++++++++
 tb/tb_codificador_alertas.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/codificador_alertas_pkg.sv
// Shared encodings for the alert encoder: temperature zones, arming states
// and a saturating subtract used to derive the hysteresis thresholds.
package codificador_alertas_pkg;

    localparam logic [1:0] ZONA_NORMAL   = 2'd0;
    localparam logic [1:0] ZONA_MEDIA    = 2'd1;
    localparam logic [1:0] ZONA_ALTA     = 2'd2;

    localparam logic [1:0] EST_DESARMADO = 2'd0;
    localparam logic [1:0] EST_ARMANDO   = 2'd1;
    localparam logic [1:0] EST_ARMADO    = 2'd2;

    typedef enum logic [1:0] {
        NORMAL = ZONA_NORMAL,
        MEDIA  = ZONA_MEDIA,
        ALTA   = ZONA_ALTA
    } zona_t;

    typedef enum logic [1:0] {
        DESARMADO = EST_DESARMADO,
        ARMANDO   = EST_ARMANDO,
        ARMADO    = EST_ARMADO
    } estado_t;

    // Threshold minus hysteresis, clamped at zero so a small threshold never wraps.
    function automatic logic [7:0] sat_sub(input logic [7:0] a, input logic [7:0] b);
        return (a >= b) ? (a - b) : 8'd0;
    endfunction

endpackage

// File: rtl/codificador_alertas_if.sv
// Sensor-side samples into the encoder and the six condition flags out of it.
interface codificador_alertas_if;
    logic       dato_valido;
    logic [7:0] temp_dato;
    logic [7:0] frec_dato;
    logic       humo_in;
    logic       posicion_in;
    logic       boton_act;
    logic       TempAlta;
    logic       TempMedia;
    logic       FrecCard;
    logic       Humo;
    logic       Posicion;
    logic       Activacion;

    modport master (
        output dato_valido, temp_dato, frec_dato, humo_in, posicion_in, boton_act,
        input  TempAlta, TempMedia, FrecCard, Humo, Posicion, Activacion
    );

    modport slave (
        input  dato_valido, temp_dato, frec_dato, humo_in, posicion_in, boton_act,
        output TempAlta, TempMedia, FrecCard, Humo, Posicion, Activacion
    );
endinterface

// File: rtl/codificador_alertas_antirrebote.sv
// Two-flop synchronizer followed by a debouncer: the output follows the
// synchronized input only after DEB_CICLOS consecutive differing cycles.
module antirrebote #(
    parameter int DEB_CICLOS = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic out
);
    localparam int DW = $clog2(DEB_CICLOS + 1);

    logic          s1_reg;
    logic          s2_reg;
    logic          out_reg;
    logic [DW-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_reg  <= 1'b0;
            s2_reg  <= 1'b0;
            out_reg <= 1'b0;
            cnt_reg <= '0;
        end else begin
            s1_reg <= in;
            s2_reg <= s1_reg;
            if (s2_reg != out_reg) begin
                if (cnt_reg == DW'(DEB_CICLOS - 1)) begin
                    out_reg <= s2_reg;
                    cnt_reg <= '0;
                end else begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end else begin
                cnt_reg <= '0;
            end
        end
    end

    assign out = out_reg;
endmodule

// File: rtl/codificador_alertas.sv
// Turns raw sensor samples into six registered, glitch-free condition flags
// using hysteresis, sample confirmation, debouncing and an arming delay.
module codificador_alertas
    import codificador_alertas_pkg::*;
#(
    parameter logic [7:0] T_MEDIA    = 8'd37,
    parameter logic [7:0] T_ALTA     = 8'd39,
    parameter logic [7:0] T_HIST     = 8'd1,
    parameter logic [7:0] F_MIN      = 8'd50,
    parameter logic [7:0] F_MAX      = 8'd120,
    parameter logic [7:0] F_HIST     = 8'd5,
    parameter int         CONFIRM    = 3,
    parameter int         DEB_CICLOS = 16,
    parameter int         ARM_DELAY  = 32
) (
    input logic                  clk,
    input logic                  reset,
    codificador_alertas_if.slave bus
);
    localparam int CW = $clog2(CONFIRM + 1);
    localparam int AW = $clog2(ARM_DELAY + 1);

    localparam logic [7:0] T_MEDIA_BAJA = sat_sub(T_MEDIA, T_HIST);
    localparam logic [7:0] T_ALTA_BAJA  = sat_sub(T_ALTA, T_HIST);
    localparam logic [7:0] F_MIN_ALTO   = F_MIN + F_HIST;
    localparam logic [7:0] F_MAX_BAJO   = sat_sub(F_MAX, F_HIST);

    // ---------------- temperature zone with confirmation ----------------
    zona_t         zona_reg;
    zona_t         cand_t_prev_reg;
    zona_t         cand_t;
    logic [CW-1:0] cnt_t_reg;
    logic [CW-1:0] cnt_t_inc;
    logic          tempalta_reg;
    logic          tempmedia_reg;

    always_comb begin
        cand_t = zona_reg;
        case (zona_reg)
            NORMAL: begin
                if (bus.temp_dato >= T_ALTA)       cand_t = ALTA;
                else if (bus.temp_dato >= T_MEDIA) cand_t = MEDIA;
                else                               cand_t = NORMAL;
            end
            MEDIA: begin
                if (bus.temp_dato >= T_ALTA)           cand_t = ALTA;
                else if (bus.temp_dato < T_MEDIA_BAJA) cand_t = NORMAL;
                else                                   cand_t = MEDIA;
            end
            ALTA: begin
                if (bus.temp_dato < T_MEDIA_BAJA)     cand_t = NORMAL;
                else if (bus.temp_dato < T_ALTA_BAJA) cand_t = MEDIA;
                else                                  cand_t = ALTA;
            end
            default: cand_t = NORMAL;
        endcase
        cnt_t_inc = (cand_t == cand_t_prev_reg && cnt_t_reg != '0) ? cnt_t_reg + 1'b1 : CW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            zona_reg        <= NORMAL;
            cand_t_prev_reg <= NORMAL;
            cnt_t_reg       <= '0;
            tempalta_reg    <= 1'b0;
            tempmedia_reg   <= 1'b0;
        end else if (bus.dato_valido) begin
            cand_t_prev_reg <= cand_t;
            if (cand_t == zona_reg) begin
                cnt_t_reg <= '0;
            end else if (cnt_t_inc == CW'(CONFIRM)) begin
                zona_reg      <= cand_t;
                cnt_t_reg     <= '0;
                tempalta_reg  <= (cand_t == ALTA);
                tempmedia_reg <= (cand_t == MEDIA);
            end else begin
                cnt_t_reg <= cnt_t_inc;
            end
        end
    end

    // ---------------- heart-rate flag with confirmation ----------------
    logic          frec_reg;
    logic          cand_f;
    logic          cand_f_prev_reg;
    logic [CW-1:0] cnt_f_reg;
    logic [CW-1:0] cnt_f_inc;

    always_comb begin
        if (frec_reg)
            cand_f = !(bus.frec_dato >= F_MIN_ALTO && bus.frec_dato <= F_MAX_BAJO);
        else
            cand_f = (bus.frec_dato < F_MIN) || (bus.frec_dato > F_MAX);
        cnt_f_inc = (cand_f == cand_f_prev_reg && cnt_f_reg != '0) ? cnt_f_reg + 1'b1 : CW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            frec_reg        <= 1'b0;
            cand_f_prev_reg <= 1'b0;
            cnt_f_reg       <= '0;
        end else if (bus.dato_valido) begin
            cand_f_prev_reg <= cand_f;
            if (cand_f == frec_reg) begin
                cnt_f_reg <= '0;
            end else if (cnt_f_inc == CW'(CONFIRM)) begin
                frec_reg  <= cand_f;
                cnt_f_reg <= '0;
            end else begin
                cnt_f_reg <= cnt_f_inc;
            end
        end
    end

    // ---------------- debouncers: [0]=humo, [1]=posicion, [2]=boton ----------------
    logic [2:0] raw;
    logic [2:0] deb;

    assign raw = {bus.boton_act, bus.posicion_in, bus.humo_in};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_deb
            antirrebote #(.DEB_CICLOS(DEB_CICLOS)) u_deb (
                .clk   (clk),
                .reset (reset),
                .in    (raw[gi]),
                .out   (deb[gi])
            );
        end
    endgenerate

    // ---------------- arming FSM ----------------
    estado_t       estado_reg;
    estado_t       estado_next;
    logic [AW-1:0] cnt_a_reg;
    logic [AW-1:0] cnt_a_next;
    logic          boton_prev_reg;
    logic          pulso;
    logic          act_reg;

    assign pulso = deb[2] & ~boton_prev_reg;

    always_comb begin
        estado_next = estado_reg;
        cnt_a_next  = cnt_a_reg;
        case (estado_reg)
            DESARMADO: begin
                if (pulso) begin
                    estado_next = ARMANDO;
                    cnt_a_next  = '0;
                end
            end
            ARMANDO: begin
                // A press on the expiry cycle cancels rather than arms.
                if (pulso) begin
                    estado_next = DESARMADO;
                    cnt_a_next  = '0;
                end else if (cnt_a_reg == AW'(ARM_DELAY - 1)) begin
                    estado_next = ARMADO;
                    cnt_a_next  = '0;
                end else begin
                    cnt_a_next = cnt_a_reg + 1'b1;
                end
            end
            ARMADO: begin
                if (pulso) estado_next = DESARMADO;
            end
            default: begin
                estado_next = DESARMADO;
                cnt_a_next  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            estado_reg     <= DESARMADO;
            cnt_a_reg      <= '0;
            boton_prev_reg <= 1'b0;
            act_reg        <= 1'b0;
        end else begin
            estado_reg     <= estado_next;
            cnt_a_reg      <= cnt_a_next;
            boton_prev_reg <= deb[2];
            act_reg        <= (estado_next == ARMADO);
        end
    end

    assign bus.TempAlta   = tempalta_reg;
    assign bus.TempMedia  = tempmedia_reg;
    assign bus.FrecCard   = frec_reg;
    assign bus.Humo       = deb[0];
    assign bus.Posicion   = deb[1];
    assign bus.Activacion = act_reg;
endmodule

// File: tb/tb_codificador_alertas.sv
// Directed bench for codificador_alertas; a second instance with a longer
// arming delay makes a cancel-during-arming press reachable.
module tb_codificador_alertas;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    codificador_alertas_if bus();
    codificador_alertas_if bc();

    assign bc.dato_valido = bus.dato_valido;
    assign bc.temp_dato   = bus.temp_dato;
    assign bc.frec_dato   = bus.frec_dato;
    assign bc.humo_in     = bus.humo_in;
    assign bc.posicion_in = bus.posicion_in;
    assign bc.boton_act   = bus.boton_act;

    codificador_alertas dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    codificador_alertas #(.ARM_DELAY(64)) dut_c (
        .clk   (clk),
        .reset (reset),
        .bus   (bc)
    );

    function automatic logic [5:0] flags();
        return {bus.TempAlta, bus.TempMedia, bus.FrecCard, bus.Humo, bus.Posicion, bus.Activacion};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        bus.dato_valido = 1'b0;
        bus.humo_in = 1'b0;
        bus.posicion_in = 1'b0;
        bus.boton_act = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic strobe(input logic [7:0] t, input logic [7:0] f);
        @(negedge clk);
        bus.dato_valido = 1'b1;
        bus.temp_dato = t;
        bus.frec_dato = f;
        @(negedge clk);
        bus.dato_valido = 1'b0;
    endtask

    task automatic set_raw(input int sel, input logic v);
        if (sel == 0) bus.humo_in = v;
        else          bus.posicion_in = v;
    endtask

    function automatic logic deb_out(input int sel);
        return (sel == 0) ? bus.Humo : bus.Posicion;
    endfunction

    task automatic test_reset();
        bus.temp_dato = 8'd0;
        bus.frec_dato = 8'd0;
        do_reset();
        checks++;
        if (flags() !== 6'b0) begin
            failures++;
            $display("FAIL reset_outputs got=%b expected=000000", flags());
        end
        for (int i = 0; i < 5; i++) strobe(8'd36, 8'd80);
        checks++;
        if (flags() !== 6'b0) begin
            failures++;
            $display("FAIL normal_samples got=%b expected=000000", flags());
        end
        $display("test_reset done");
    endtask

    task automatic test_temp();
        logic [7:0] t_vec [14];
        logic [1:0] e_vec [14];
        t_vec = '{8'd38, 8'd38, 8'd38, 8'd38, 8'd40, 8'd38, 8'd40, 8'd40, 8'd40,
                  8'd38, 8'd38, 8'd38, 8'd37, 8'd37};
        e_vec = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10,
                  2'b10, 2'b10, 2'b10, 2'b10, 2'b10};
        for (int i = 0; i < 14; i++) begin
            strobe(t_vec[i], 8'd80);
            checks++;
            if ({bus.TempAlta, bus.TempMedia} !== e_vec[i]) begin
                failures++;
                $display("FAIL temp_step%0d temp=%0d got=%b expected=%b",
                         i, t_vec[i], {bus.TempAlta, bus.TempMedia}, e_vec[i]);
            end
        end
        strobe(8'd37, 8'd80);
        checks++;
        if ({bus.TempAlta, bus.TempMedia} !== 2'b01) begin
            failures++;
            $display("FAIL temp_alta_to_media got=%b expected=01", {bus.TempAlta, bus.TempMedia});
        end
        for (int i = 0; i < 3; i++) strobe(8'd35, 8'd80);
        checks++;
        if ({bus.TempAlta, bus.TempMedia} !== 2'b00) begin
            failures++;
            $display("FAIL temp_to_normal got=%b expected=00", {bus.TempAlta, bus.TempMedia});
        end
        $display("test_temp done");
    endtask

    task automatic test_frec();
        logic [7:0] f_vec [20];
        logic       e_vec [20];
        f_vec = '{8'd120, 8'd120, 8'd120, 8'd130, 8'd130, 8'd130, 8'd118, 8'd118, 8'd118, 8'd115,
                  8'd115, 8'd115, 8'd45, 8'd45, 8'd80, 8'd45, 8'd45, 8'd45, 8'd80, 8'd80};
        e_vec = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 20; i++) begin
            strobe(8'd35, f_vec[i]);
            checks++;
            if (bus.FrecCard !== e_vec[i]) begin
                failures++;
                $display("FAIL frec_step%0d frec=%0d got=%b expected=%b",
                         i, f_vec[i], bus.FrecCard, e_vec[i]);
            end
        end
        strobe(8'd35, 8'd80);
        checks++;
        if (bus.FrecCard !== 1'b0) begin
            failures++;
            $display("FAIL frec_recover got=%b expected=0", bus.FrecCard);
        end
        $display("test_frec done");
    endtask

    task automatic test_debounce(input int sel);
        logic seen;
        seen = 1'b0;
        @(negedge clk);
        set_raw(sel, 1'b1);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i == 9) set_raw(sel, 1'b0);
            seen = seen | deb_out(sel);
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL deb%0d_short_pulse got=%b expected=0", sel, seen);
        end
        set_raw(sel, 1'b1);
        repeat (17) @(negedge clk);
        checks++;
        if (deb_out(sel) !== 1'b0) begin
            failures++;
            $display("FAIL deb%0d_early got=%b expected=0", sel, deb_out(sel));
        end
        @(negedge clk);
        checks++;
        if (deb_out(sel) !== 1'b1) begin
            failures++;
            $display("FAIL deb%0d_rise got=%b expected=1", sel, deb_out(sel));
        end
        repeat (2) @(negedge clk);
        set_raw(sel, 1'b0);
        repeat (40) @(negedge clk);
        checks++;
        if (deb_out(sel) !== 1'b0) begin
            failures++;
            $display("FAIL deb%0d_fall got=%b expected=0", sel, deb_out(sel));
        end
        $display("test_debounce sel=%0d done", sel);
    endtask

    task automatic test_arm();
        @(negedge clk);
        bus.boton_act = 1'b1;
        for (int i = 1; i <= 50; i++) begin
            @(negedge clk);
            if (i == 20) bus.boton_act = 1'b0;
        end
        checks++;
        if (bus.Activacion !== 1'b0) begin
            failures++;
            $display("FAIL arm_early got=%b expected=0", bus.Activacion);
        end
        @(negedge clk);
        checks++;
        if (bus.Activacion !== 1'b1) begin
            failures++;
            $display("FAIL arm_rise got=%b expected=1", bus.Activacion);
        end
        repeat (40) @(negedge clk);
        bus.boton_act = 1'b1;
        repeat (18) @(negedge clk);
        checks++;
        if (bus.Activacion !== 1'b1) begin
            failures++;
            $display("FAIL disarm_early got=%b expected=1", bus.Activacion);
        end
        @(negedge clk);
        checks++;
        if (bus.Activacion !== 1'b0) begin
            failures++;
            $display("FAIL disarm got=%b expected=0", bus.Activacion);
        end
        bus.boton_act = 1'b0;
        repeat (40) @(negedge clk);
        $display("test_arm done");
    endtask

    task automatic test_cancel();
        logic seen;
        seen = 1'b0;
        do_reset();
        bus.boton_act = 1'b1;
        for (int i = 1; i <= 120; i++) begin
            @(negedge clk);
            if (i == 18) bus.boton_act = 1'b0;
            if (i == 36) bus.boton_act = 1'b1;
            if (i == 56) bus.boton_act = 1'b0;
            seen = seen | bc.Activacion;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL arm_cancel got=%b expected=0", seen);
        end
        repeat (40) @(negedge clk);
        $display("test_cancel done");
    endtask

    task automatic test_reset_mid();
        logic seen;
        seen = 1'b0;
        do_reset();
        for (int i = 0; i < 3; i++) strobe(8'd40, 8'd80);
        checks++;
        if (bus.TempAlta !== 1'b1) begin
            failures++;
            $display("FAIL mid_setup_alta got=%b expected=1", bus.TempAlta);
        end
        bus.boton_act = 1'b1;
        repeat (20) @(negedge clk);
        bus.boton_act = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (flags() !== 6'b0) begin
            failures++;
            $display("FAIL mid_reset_outputs got=%b expected=000000", flags());
        end
        strobe(8'd40, 8'd80);
        strobe(8'd40, 8'd80);
        checks++;
        if (bus.TempAlta !== 1'b0) begin
            failures++;
            $display("FAIL mid_reconfirm_early got=%b expected=0", bus.TempAlta);
        end
        strobe(8'd40, 8'd80);
        checks++;
        if (bus.TempAlta !== 1'b1) begin
            failures++;
            $display("FAIL mid_reconfirm got=%b expected=1", bus.TempAlta);
        end
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            seen = seen | bus.Activacion;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL mid_arm_aborted got=%b expected=0", seen);
        end
        $display("test_reset_mid done");
    endtask

    initial begin
        reset = 1'b1;
        bus.dato_valido = 1'b0;
        bus.temp_dato = 8'd0;
        bus.frec_dato = 8'd0;
        bus.humo_in = 1'b0;
        bus.posicion_in = 1'b0;
        bus.boton_act = 1'b0;
        test_reset();
        test_temp();
        test_frec();
        test_debounce(0);
        test_debounce(1);
        test_arm();
        test_cancel();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
